// File: rtl/wisard_addr_gen_if.sv
// Sample-in / address-beat-out bus of the WiSARD address generator.
// Sink: a sample transfers on a rising edge where sink_valid && sink_ready; the
// producer holds sink_data stable while sink_valid=1 and sink_ready=0. Source:
// a beat is valid while source_valid=1. The source has no back-pressure.
interface wisard_addr_gen_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 4,
  parameter int N_RAMS        = 16
);
  logic                            sink_valid;
  logic                            sink_ready;
  logic [N_RAMS*ADDRESS_WIDTH-1:0] sink_data;
  logic                            source_valid;
  logic                            sop;
  logic                            eop;
  logic [ADDRESS_WIDTH-1:0]        addr;
  logic [INDEX_WIDTH-1:0]          index;

  modport master (
    output sink_valid, sink_data,
    input  sink_ready, source_valid, sop, eop, addr, index
  );

  modport slave (
    input  sink_valid, sink_data,
    output sink_ready, source_valid, sop, eop, addr, index
  );
endinterface

// File: rtl/wisard_addr_gen.sv
// Splits each sample into N_RAMS (index, address) beats, then idles GAP_CYCLES cycles.
// Optional macro WISARD_ADDR_GEN_DOUBLE_BUF_EN adds a one-deep pending sample buffer.
module wisard_addr_gen #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 4,
  parameter int N_RAMS        = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wisard_addr_gen_if.slave   bus,
  output logic [1:0]         state_dbg
);
  localparam int SW = N_RAMS * ADDRESS_WIDTH;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [INDEX_WIDTH:0] N_BEATS   = (INDEX_WIDTH+1)'(N_RAMS);
  localparam logic [INDEX_WIDTH:0] LAST_BEAT = (INDEX_WIDTH+1)'(N_RAMS - 1);
  localparam logic [INDEX_WIDTH:0] ONE_BEAT  = (INDEX_WIDTH+1)'(1);
  localparam logic [GW-1:0]        GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, GAP = 2'd2} state_t;

  state_t                   state, state_d;
  logic [SW-1:0]            sample, sample_d;
  logic [INDEX_WIDTH:0]     beat_cnt, beat_d;
  logic [GW-1:0]            gap_cnt, gap_d;
  logic                     valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic                     ready, accept, launch, take_next;
  logic [SW-1:0]            launch_data;

`ifdef WISARD_ADDR_GEN_DOUBLE_BUF_EN
  logic          pend_full, pend_full_d;
  logic [SW-1:0] pend_data, pend_data_d;
  assign ready = !pend_full;
`else
  assign ready = (state == IDLE);
`endif

  assign accept = bus.sink_valid && ready;

  always_comb begin
    state_d     = state;
    sample_d    = sample;
    beat_d      = beat_cnt;
    gap_d       = gap_cnt;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    addr_d      = addr_q;
    index_d     = index_q;
    launch      = 1'b0;
    take_next   = 1'b0;
    launch_data = bus.sink_data;
`ifdef WISARD_ADDR_GEN_DOUBLE_BUF_EN
    pend_full_d = pend_full;
    pend_data_d = pend_data;
`endif

    case (state)
      IDLE: launch = accept;
      EMIT: begin
        // beat_cnt is the number of beats already driven; at N_BEATS the eop beat is on the bus
        if (beat_cnt < N_BEATS) begin
          valid_d = 1'b1;
          eop_d   = (beat_cnt == LAST_BEAT);
          addr_d  = sample[int'(beat_cnt)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          index_d = beat_cnt[INDEX_WIDTH-1:0];
          beat_d  = beat_cnt + ONE_BEAT;
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = '0;
        end else begin
          take_next = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) take_next = 1'b1;
        else                     gap_d = gap_cnt + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (take_next) begin
`ifdef WISARD_ADDR_GEN_DOUBLE_BUF_EN
      // A sample arriving on the very cycle the gap ends starts straight away
      if (pend_full) begin
        launch      = 1'b1;
        launch_data = pend_data;
        pend_full_d = 1'b0;
      end else if (accept) begin
        launch = 1'b1;
      end else begin
        state_d = IDLE;
      end
`else
      state_d = IDLE;
`endif
    end

`ifdef WISARD_ADDR_GEN_DOUBLE_BUF_EN
    if (accept && !launch) begin
      pend_full_d = 1'b1;
      pend_data_d = bus.sink_data;
    end
`endif

    if (launch) begin
      state_d  = EMIT;
      sample_d = launch_data;
      beat_d   = ONE_BEAT;
      valid_d  = 1'b1;
      sop_d    = 1'b1;
      eop_d    = (N_RAMS == 1);
      addr_d   = launch_data[ADDRESS_WIDTH-1:0];
      index_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sample   <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      addr_q   <= '0;
      index_q  <= '0;
`ifdef WISARD_ADDR_GEN_DOUBLE_BUF_EN
      pend_full <= 1'b0;
      pend_data <= '0;
`endif
    end else begin
      state    <= state_d;
      sample   <= sample_d;
      beat_cnt <= beat_d;
      gap_cnt  <= gap_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      addr_q   <= addr_d;
      index_q  <= index_d;
`ifdef WISARD_ADDR_GEN_DOUBLE_BUF_EN
      pend_full <= pend_full_d;
      pend_data <= pend_data_d;
`endif
    end
  end

  assign bus.sink_ready   = ready;
  assign bus.source_valid = valid_q;
  assign bus.sop          = sop_q;
  assign bus.eop          = eop_q;
  assign bus.addr         = addr_q;
  assign bus.index        = index_q;
  assign state_dbg        = state;
endmodule
